// File: rtl/vga_text_renderer_pkg.sv
// Shared 640x480@60 timing constants, text-buffer geometry and cell addressing
// for the VGA text renderer.
package vga_text_pkg;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FP      = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BP      = 10'd48;
    localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] H_LAST    = H_TOTAL - 10'd1;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;

    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FP      = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BP      = 10'd33;
    localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] V_LAST    = V_TOTAL - 10'd1;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

    localparam logic [11:0] TEXT_COLS  = 12'd80;
    localparam logic [11:0] TEXT_ROWS  = 12'd30;
    localparam int          TEXT_CELLS = 2400;
    localparam int          GLYPH_W    = 8;
    localparam int          GLYPH_H    = 16;

    // Cell under the beam; beyond the visible area the result may exceed the
    // buffer and is treated as don't-care by the reader.
    function automatic logic [11:0] cell_index(input logic [9:0] h, input logic [9:0] v);
        return {6'd0, v[9:4]} * TEXT_COLS + {5'd0, h[9:3]};
    endfunction

endpackage

// File: rtl/vga_text_renderer_text_ram.sv
// 2400x8 text buffer: one write port, one synchronous read port that returns
// the old contents when a write hits the same cell in the same cycle.
module text_ram
    import vga_text_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [11:0] waddr,
    input  logic [7:0]  wdata,
    input  logic        re,
    input  logic [11:0] raddr,
    output logic [7:0]  rdata
);

    localparam logic [11:0] CELL_LIMIT = 12'(TEXT_CELLS);

    logic [7:0] mem [0:TEXT_CELLS-1];

    always_ff @(posedge clk) begin
        if (we && (waddr < CELL_LIMIT)) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (raddr < CELL_LIMIT) ? mem[raddr] : 8'h00;
        end
    end

endmodule

// File: rtl/vga_text_renderer.sv
// 80x30 text-mode VGA renderer: 640x480@60 timing, text buffer lookup and
// MSB-first glyph serialisation. Optional macro TEXT_INVERSE_EN: code[7] inverts the cell.
module vga_text_renderer
    import vga_text_pkg::*;
#(
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [11:0] rgb
);

    function automatic logic [11:0] pixel_color(input logic vis, input logic on);
        if (!vis) return 12'h000;
        return on ? FG_COLOR : BG_COLOR;
    endfunction

    logic [9:0]  h_p0, v_p0;
    logic        h_wrap, v_wrap;
    logic [7:0]  code_p1;
    logic [2:0]  hpix_p1;
    logic [3:0]  vrow_p1;
    logic        hs_p1, vs_p1, vld_p1;
    logic        inv_p1, pat_bit;
    logic        hs_p2, vs_p2, vld_p2;
    logic [11:0] rgb_p2;

    assign h_wrap = (h_p0 == H_LAST);
    assign v_wrap = (v_p0 == V_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_p0 <= '0;
            v_p0 <= '0;
        end else if (pix_en) begin
            h_p0 <= h_wrap ? 10'd0 : h_p0 + 10'd1;
            if (h_wrap) begin
                v_p0 <= v_wrap ? 10'd0 : v_p0 + 10'd1;
            end
        end
    end

    // Stage 1: character code fetch, with position and raw timing carried alongside
    text_ram u_text_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (pix_en),
        .raddr (cell_index(h_p0, v_p0)),
        .rdata (code_p1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpix_p1 <= '0;
            vrow_p1 <= '0;
            hs_p1   <= 1'b0;
            vs_p1   <= 1'b0;
            vld_p1  <= 1'b0;
        end else if (pix_en) begin
            hpix_p1 <= h_p0[2:0];
            vrow_p1 <= v_p0[3:0];
            hs_p1   <= (h_p0 >= H_SYNC_START) && (h_p0 <= H_SYNC_END);
            vs_p1   <= (v_p0 >= V_SYNC_START) && (v_p0 <= V_SYNC_END);
            vld_p1  <= (h_p0 < H_VISIBLE) && (v_p0 < V_VISIBLE);
        end
    end

`ifdef TEXT_INVERSE_EN
    assign inv_p1 = code_p1[7];
`else
    logic unused_code7;
    assign unused_code7 = code_p1[7];
    assign inv_p1       = 1'b0;
`endif

    // Stage 2: glyph line from the ROM, pick the pixel bit and colour it
    assign rom_addr = {code_p1[6:0], vrow_p1};
    assign pat_bit  = rom_data[3'd7 - hpix_p1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_p2  <= 1'b0;
            vs_p2  <= 1'b0;
            vld_p2 <= 1'b0;
            rgb_p2 <= '0;
        end else if (pix_en) begin
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            vld_p2 <= vld_p1;
            rgb_p2 <= pixel_color(vld_p1, pat_bit ^ inv_p1);
        end
    end

    assign hsync    = ~hs_p2;
    assign vsync    = ~vs_p2;
    assign video_on = vld_p2;
    assign rgb      = rgb_p2;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer: reset, line timing, glyph serialisation,
// write-port bounds and pixel-enable gating against a small frame model.
module tb_vga_text_renderer;

    logic        clk = 1'b0;
    logic        rst_n, pix_en, wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data, rom_data;
    logic [10:0] rom_addr;
    logic        hsync, vsync, video_on;
    logic [11:0] rgb;

    int checks = 0;
    int errors = 0;

    logic [7:0] tbuf [0:2399];

    localparam logic [14:0] RST_PACK = {1'b1, 1'b1, 1'b0, 12'h000};

    logic [11:0] exp_norm [8] = '{12'h000, 12'h000, 12'h000, 12'hFFF,
                                  12'hFFF, 12'h000, 12'h000, 12'h000};
`ifdef TEXT_INVERSE_EN
    logic [11:0] exp_cell0 [8] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h000,
                                   12'h000, 12'hFFF, 12'hFFF, 12'hFFF};
`else
    logic [11:0] exp_cell0 [8] = '{12'h000, 12'h000, 12'h000, 12'hFFF,
                                   12'hFFF, 12'h000, 12'h000, 12'h000};
`endif

    always #5 clk = ~clk;

    vga_text_renderer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_en   (pix_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .hsync    (hsync),
        .vsync    (vsync),
        .video_on (video_on),
        .rgb      (rgb)
    );

    // Glyph ROM contents: 'A' = 0x18 then 0x81, 'B' = solid, everything else blank
    function automatic logic [7:0] rom_f(input logic [10:0] a);
        case (a[10:4])
            7'h41:   return (a[3:0] == 4'd0) ? 8'h18 : 8'h81;
            7'h42:   return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    always_comb rom_data = rom_f(rom_addr);

    function automatic logic [14:0] model(input int n);
        int x, y;
        logic hs, vs, vis, on;
        logic [7:0] code, line;
        logic [11:0] col;
        x = n % 800;
        y = (n / 800) % 525;
        hs = (x >= 656) && (x <= 751);
        vs = (y >= 490) && (y <= 491);
        vis = (x < 640) && (y < 480);
        code = 8'h00;
        line = 8'h00;
        on = 1'b0;
        col = 12'h000;
        if (vis) begin
            code = tbuf[(y / 16) * 80 + x / 8];
            line = rom_f({code[6:0], 4'(y % 16)});
            on = line[7 - (x % 8)];
`ifdef TEXT_INVERSE_EN
            on = on ^ code[7];
`endif
            col = on ? 12'hFFF : 12'h000;
        end
        return {~hs, ~vs, vis, col};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ram_write(input logic [11:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (a < 12'd2400) tbuf[a] = d;
    endtask

    initial begin
        logic [14:0] exp;
        logic prev_hs;
        int fall_t [2];
        int nfall, rise_t, vis_line0, vis_all, t, c;
        logic do_wr;

        rst_n = 1'b0;
        pix_en = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2400; i++) ram_write(12'(i), 8'h20);
        check("reset_outputs", 32'({hsync, vsync, video_on, rgb}), 32'(RST_PACK));
        check("reset_rom_addr", 32'(rom_addr), 32'h0);

        ram_write(12'd0, 8'hC1);
        ram_write(12'd1, 8'h41);
        ram_write(12'd100, 8'h42);
        ram_write(12'd399, 8'h41);
        ram_write(12'd2400, 8'h42);
        ram_write(12'd2399, 8'h41);

        // Run part of a frame, then reset mid-frame
        rst_n = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("midframe_reset", 32'({hsync, vsync, video_on, rgb}), 32'(RST_PACK));
            check("midframe_rom_addr", 32'(rom_addr), 32'h0);
        end
        rst_n = 1'b1;

        prev_hs = 1'b1;
        nfall = 0;
        rise_t = 0;
        vis_line0 = 0;
        vis_all = 0;
        fall_t[0] = 0;
        fall_t[1] = 0;
        for (int tc = 1; tc <= 64001; tc++) begin
            @(posedge clk);
            #1;
            exp = (tc >= 2) ? model(tc - 2) : RST_PACK;
            check("run", 32'({hsync, vsync, video_on, rgb}), 32'(exp));
            if (tc == 1 || tc == 9) check("rom_addr_A", 32'(rom_addr), 32'h410);
            if (tc == 17) check("rom_addr_space", 32'(rom_addr), 32'h200);
            if (tc >= 2 && tc <= 9) check("cell0_pixel", 32'(rgb), 32'(exp_cell0[tc - 2]));
            if (tc >= 10 && tc <= 17) check("cell1_pixel", 32'(rgb), 32'(exp_norm[tc - 10]));
            if (tc >= 51834 && tc <= 51841) check("cell399_pixel", 32'(rgb), 32'(exp_norm[tc - 51834]));
            if (tc == 12962) check("cell100_pixel", 32'(rgb), 32'hFFF);
            if (prev_hs && !hsync && nfall < 2) begin
                fall_t[nfall] = tc;
                nfall++;
            end
            if (!prev_hs && hsync && rise_t == 0) rise_t = tc;
            prev_hs = hsync;
            if (video_on) begin
                vis_all++;
                if (tc <= 801) vis_line0++;
            end
        end
        check("hsync_first_fall", 32'(fall_t[0]), 32'd658);
        check("hsync_low_width", 32'(rise_t - fall_t[0]), 32'd96);
        check("hsync_period", 32'(fall_t[1] - fall_t[0]), 32'd800);
        check("video_on_line0", 32'(vis_line0), 32'd640);
        check("video_on_80_lines", 32'(vis_all), 32'd51200);

        // Gated run: one pixel every second clock, with a write while gated
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        t = 0;
        for (c = 0; c < 2 * 2402; c++) begin
            pix_en = (c % 2 == 0);
            if (pix_en) t++;
            do_wr = !pix_en && (t == 1202);
            if (do_wr) begin
                wr_en = 1'b1;
                wr_addr = 12'd0;
                wr_data = 8'h42;
            end
            @(posedge clk);
            #1;
            if (do_wr) begin
                wr_en = 1'b0;
                tbuf[0] = 8'h42;
            end
            exp = (t >= 2) ? model(t - 2) : RST_PACK;
            check("gated", 32'({hsync, vsync, video_on, rgb}), 32'(exp));
            if (t == 1602) check("gated_write_visible", 32'(rgb), 32'hFFF);
        end
        pix_en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
